blackjack_round_ctrl: RTL and testbench
=======================================

Name: blackjack_round_ctrl

Overview:
Parametrised blackjack round controller, the successor of the single-split game core. It supports up to MAX_HANDS player hands through repeated splits, plus double-down, configurable coin width and a configurable dealer stand threshold. Cards come from an external deck block over a req/valid handshake. It sits under the board top and drives the score/coin displays and the Win/Lose/Draw LEDs.

Parameters:
COIN_W, 5, coin register width; the coin count saturates at 2^COIN_W-1.
SCORE_W, 6, width of score and card outputs.
MAX_HANDS, 2, maximum player hands, legal range 1..4; HW=$clog2(MAX_HANDS), minimum 1.
INIT_COIN, 10, coin value after reset.
DEALER_STAND, 17, dealer stops drawing at a score ≥ this; soft 17 stands.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
next  in  1  one-cycle pulse: start the round / acknowledge the result
hit  in  1  one-cycle pulse
stand  in  1  one-cycle pulse
double  in  1  one-cycle pulse
split  in  1  one-cycle pulse
bet  in  4  wager, 0..15
card_req  out  1  request a card from the deck
card_valid  in  1  deck presents a card
card_value  in  4  1=ace, 2..10; 0 and 11..15 are treated as 10
hand_sel  in  HW  selects the hand shown on player_* and Win/Lose/Draw
player_score  out  SCORE_W  best score of the selected hand
player_new_card  out  SCORE_W  last card dealt to the selected hand
dealer_score  out  SCORE_W  dealer best score
active_hand  out  HW  hand currently being played
num_hands  out  HW+1  number of hands in play
current_coin  out  COIN_W  coin balance
can_split  out  1  split is legal now
can_double  out  1  double is legal now
result_valid  out  1  settlement is done
Win  out  1  selected hand won
Lose  out  1  selected hand lost
Draw  out  1  selected hand pushed

Behaviour:
- Reset, asynchronous, any state: state=IDLE, current_coin=INIT_COIN; every other output and internal register is 0.
- States: IDLE, DEAL, PLAY, PDRAW, DEALER, DDRAW, SETTLE, DONE.
- IDLE
  - next with 1 ≤ bet ≤ current_coin: debit bet from the coin, set num_hands=1, go to DEAL.
  - Any other bet: next is ignored. With coin=0 the game stays in IDLE permanently.
- Card handshake
  - card_req rises in the cycle after the controller enters a draw step.
  - card_req holds until a cycle with card_valid=1; the card is consumed in that cycle.
  - card_req is 0 in the following cycle.
  - card_valid while card_req=0 is ignored.
- DEAL: draws four cards in the order player, dealer, player, dealer, then goes to PLAY with active_hand=0.
- Scoring
  - Per hand: hard sum plus an ace flag.
  - Best score = hard+10 if an ace is present and hard+10 ≤ 21, otherwise hard.
  - Bust = best > 21.
- PLAY, one action per cycle, priority stand > double > split > hit:
  - stand: the hand is finished.
  - hit: PDRAW one card. After the draw, a hand that busts or reaches 21 is finished automatically; otherwise return to PLAY.
  - double: legal only on a 2-card hand with coin ≥ that hand's bet. Debit the coin, double the hand's bet, draw one card; the hand is then finished.
  - split: legal only on a 2-card hand whose two cards have equal value, with num_hands < MAX_HANDS and coin ≥ bet.
    - The new hand index is num_hands and takes the second card with bet equal to the original bet.
    - Draw one card to the active hand, then one card to the new hand, then increment num_hands.
  - Illegal actions are ignored.
  - can_split and can_double are combinational from the current state and are 0 outside PLAY.
- Hand finished: advance active_hand. After the last hand, go to DEALER.
- DEALER
  - If every hand busted, skip straight to SETTLE.
  - Otherwise DDRAW while dealer best < DEALER_STAND, then SETTLE.
- SETTLE, one hand per cycle:
  - Player bust → lose.
  - Else dealer bust or player > dealer → win; credit 2×bet.
  - Equal scores → draw; credit bet.
  - Else lose.
  - Credits saturate at 2^COIN_W-1. After the last hand, go to DONE.
- DONE: result_valid=1 and Win/Lose/Draw are decoded for hand_sel (all 0 when hand_sel ≥ num_hands). next clears the flags and returns to IDLE.
- Pulses on next/hit/stand/double/split in states where they do not apply are ignored.

Optional Feature:
BLACKJACK_BONUS_EN
- Defined: a natural (2-card 21 on an unsplit round, num_hands=1) against a non-natural dealer wins and credits 2×bet + (bet>>1), saturating. A dealer natural against a player natural is a draw.
- Undefined: a natural is scored as an ordinary 21.

Test Plan:
- Reset low mid-PDRAW with card_req=1 → card_req=0, current_coin=10, all flags 0, state IDLE; after release, next with bet=3 → coin=7, card_req=1.
- bet=3; deck 10,7,9,10; stand; dealer 17 stands → player 19 vs 17: Win=1, coin=10−3+6=13.
- Deck 8,10,8,6; split; draws 3 then 10; hand0 stand (11); hand1 hit 5 → 23 bust; dealer draws 2 → 18 → hand0 Lose, hand1 Lose, coin=10−2−2=6 (bet=2).
- bet=5; deck 5,9,6,10; double; draw 10 → 21 vs 19: Win, coin=10−10+20=20; hit and stand pulsed in the same cycle → stand wins.
- COIN_W=5, coin=30, bet=15, win → coin saturates at 31. bet=0 or bet > coin in IDLE → next ignored; card_req stays 0.
- BLACKJACK_BONUS_EN, bet=4; deck 1,9,10,8 → natural vs 17: coin=10−4+10=16. Without the macro → coin=14.

Source files
------------

// File: rtl/blackjack_round_ctrl.sv
// Blackjack round controller: repeated splits, double-down and a req/valid card handshake.
// Build option BLACKJACK_BONUS_EN pays 2*bet + bet/2 on an unsplit natural.
//   state  | meaning
//   IDLE   | waiting for next with a legal bet
//   DEAL   | four opening cards: player, dealer, player, dealer
//   PLAY   | waiting for an action on active_hand
//   PDRAW  | drawing a player card (hit, double or split)
//   DEALER | deciding whether the dealer draws
//   DDRAW  | drawing a dealer card
//   SETTLE | paying out one hand per cycle
//   DONE   | results shown until next
module blackjack_round_ctrl #(
  parameter int COIN_W       = 5,
  parameter int SCORE_W      = 6,
  parameter int MAX_HANDS    = 2,
  parameter int INIT_COIN    = 10,
  parameter int DEALER_STAND = 17,
  localparam int HW = (MAX_HANDS > 1) ? $clog2(MAX_HANDS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               next,
  input  logic               hit,
  input  logic               stand,
  input  logic               double,
  input  logic               split,
  input  logic [3:0]         bet,
  output logic               card_req,
  input  logic               card_valid,
  input  logic [3:0]         card_value,
  input  logic [HW-1:0]      hand_sel,
  output logic [SCORE_W-1:0] player_score,
  output logic [SCORE_W-1:0] player_new_card,
  output logic [SCORE_W-1:0] dealer_score,
  output logic [HW-1:0]      active_hand,
  output logic [HW:0]        num_hands,
  output logic [COIN_W-1:0]  current_coin,
  output logic               can_split,
  output logic               can_double,
  output logic               result_valid,
  output logic               Win,
  output logic               Lose,
  output logic               Draw
);
  localparam int CW = COIN_W + 7;
  localparam logic [CW-1:0] COIN_MAX = CW'((1 << COIN_W) - 1);
  localparam logic [1:0] K_HIT = 2'd0, K_DBL = 2'd1, K_SPA = 2'd2, K_SPB = 2'd3;

  typedef enum logic [2:0] {IDLE, DEAL, PLAY, PDRAW, DEALER, DDRAW, SETTLE, DONE} state_t;

  state_t               state;
  logic [1:0]           step;
  logic [4:0]           hard   [MAX_HANDS];
  logic                 ace    [MAX_HANDS];
  logic [1:0]           ncards [MAX_HANDS];
  logic [3:0]           card1  [MAX_HANDS];
  logic [3:0]           last   [MAX_HANDS];
  logic [4:0]           hbet   [MAX_HANDS];
  logic [4:0]           d_hard;
  logic                 d_ace;
`ifdef BLACKJACK_BONUS_EN
  logic [1:0]           d_ncards;
`endif
  logic [HW-1:0]        active, sidx, nidx;
  logic [HW:0]          nhands;
  logic [COIN_W-1:0]    coin;
  logic                 cr, done;
  logic [MAX_HANDS-1:0] r_win, r_lose, r_draw;

  logic [3:0]    cv;
  logic [HW-1:0] tgt;
  logic [4:0]    nh_hard;
  logic          nh_ace, last_hand, settle_last, all_bust, sel_ok;
  logic [5:0]    nh_best, d_best, p_best;
  logic          start, take, p_take, d_take, do_double, do_split, s_win, s_draw;
  logic [CW-1:0] coin_w, abet_w, sbet, credit, coin_sum, coin_sat;

  function automatic logic [5:0] best_of(input logic [4:0] h, input logic a);
    return (a && h <= 5'd11) ? {1'b0, h} + 6'd10 : {1'b0, h};
  endfunction

  always_comb begin
    cv        = (card_value == 4'd0 || card_value > 4'd10) ? 4'd10 : card_value;
    nidx      = nhands[HW-1:0];
    tgt       = (state == DEAL) ? '0 : (step == K_SPB) ? nidx : active;
    nh_hard   = hard[tgt] + {1'b0, cv};
    nh_ace    = ace[tgt] | (cv == 4'd1);
    nh_best   = best_of(nh_hard, nh_ace);
    d_best    = best_of(d_hard, d_ace);
    coin_w    = CW'(coin);
    abet_w    = CW'(hbet[active]);
    last_hand   = ((HW+1)'(active) + (HW+1)'(1)) >= nhands;
    settle_last = ((HW+1)'(sidx) + (HW+1)'(1)) >= nhands;
    can_double  = (state == PLAY) && (ncards[active] == 2'd2) && (coin_w >= abet_w);
    can_split   = can_double && (card1[active] == last[active]) &&
                  (nhands < (HW+1)'(MAX_HANDS));
    start     = (state == IDLE) && next && (bet != 4'd0) && (CW'(bet) <= coin_w);
    take      = cr && card_valid;
    p_take    = take && ((state == PDRAW) || (state == DEAL && !step[0]));
    d_take    = take && ((state == DDRAW) || (state == DEAL && step[0]));
    do_double = (state == PLAY) && !stand && double && can_double;
    do_split  = (state == PLAY) && !stand && !(double && can_double) && split && can_split;
    all_bust = 1'b1;
    for (int i = 0; i < MAX_HANDS; i++)
      if ((HW+1)'(i) < nhands && best_of(hard[i], ace[i]) <= 6'd21) all_bust = 1'b0;
    p_best = best_of(hard[sidx], ace[sidx]);
    sbet   = CW'(hbet[sidx]);
    s_win  = 1'b0;
    s_draw = 1'b0;
    credit = '0;
    if (p_best <= 6'd21) begin
`ifdef BLACKJACK_BONUS_EN
      if (nhands == (HW+1)'(1) && ncards[sidx] == 2'd2 && p_best == 6'd21 &&
          !(d_ncards == 2'd2 && d_best == 6'd21)) begin
        s_win  = 1'b1;
        credit = sbet + sbet + (sbet >> 1);
      end else
`endif
      if (d_best > 6'd21 || p_best > d_best) begin
        s_win  = 1'b1;
        credit = sbet + sbet;
      end else if (p_best == d_best) begin
        s_draw = 1'b1;
        credit = sbet;
      end
    end
    coin_sum = coin_w + credit;
    coin_sat = (coin_sum > COIN_MAX) ? COIN_MAX : coin_sum;
    sel_ok          = (HW+1)'(hand_sel) < nhands;
    player_score    = SCORE_W'(best_of(hard[hand_sel], ace[hand_sel]));
    player_new_card = SCORE_W'(last[hand_sel]);
    dealer_score    = SCORE_W'(d_best);
    Win  = done && sel_ok && r_win[hand_sel];
    Lose = done && sel_ok && r_lose[hand_sel];
    Draw = done && sel_ok && r_draw[hand_sel];
  end

  assign card_req     = cr;
  assign active_hand  = active;
  assign num_hands    = nhands;
  assign current_coin = coin;
  assign result_valid = done;

  // Per-hand and dealer card bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || start) begin
      for (int i = 0; i < MAX_HANDS; i++) begin
        hard[i] <= '0; ace[i] <= 1'b0; ncards[i] <= '0;
        card1[i] <= '0; last[i] <= '0; hbet[i] <= '0;
      end
      if (reset) hbet[0] <= {1'b0, bet};
      d_hard <= '0;
      d_ace  <= 1'b0;
`ifdef BLACKJACK_BONUS_EN
      d_ncards <= '0;
`endif
    end else begin
      if (p_take) begin
        hard[tgt] <= nh_hard;
        ace[tgt]  <= nh_ace;
        last[tgt] <= cv;
        if (ncards[tgt] == 2'd0) card1[tgt] <= cv;
        if (ncards[tgt] != 2'd3) ncards[tgt] <= ncards[tgt] + 2'd1;
      end
      if (d_take) begin
        d_hard <= d_hard + {1'b0, cv};
        d_ace  <= d_ace | (cv == 4'd1);
`ifdef BLACKJACK_BONUS_EN
        if (d_ncards != 2'd3) d_ncards <= d_ncards + 2'd1;
`endif
      end
      if (do_double) hbet[active] <= hbet[active] << 1;
      if (do_split) begin
        hard[nidx]     <= {1'b0, last[active]};
        ace[nidx]      <= (last[active] == 4'd1);
        ncards[nidx]   <= 2'd1;
        card1[nidx]    <= last[active];
        last[nidx]     <= last[active];
        hbet[nidx]     <= hbet[active];
        hard[active]   <= {1'b0, card1[active]};
        ace[active]    <= (card1[active] == 4'd1);
        ncards[active] <= 2'd1;
        last[active]   <= card1[active];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      step   <= '0;
      coin   <= COIN_W'(INIT_COIN);
      active <= '0;
      sidx   <= '0;
      nhands <= '0;
      cr     <= 1'b0;
      done   <= 1'b0;
      r_win  <= '0;
      r_lose <= '0;
      r_draw <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          coin   <= COIN_W'(coin_w - CW'(bet));
          nhands <= (HW+1)'(1);
          active <= '0;
          step   <= '0;
          state  <= DEAL;
        end
        DEAL: if (!cr) cr <= 1'b1;
          else if (card_valid) begin
            cr   <= 1'b0;
            step <= step + 2'd1;
            if (step == 2'd3) state <= PLAY;
          end
        PLAY: if (stand) begin
            if (last_hand) state <= DEALER;
            else active <= active + HW'(1);
          end else if (do_double) begin
            coin  <= COIN_W'(coin_w - abet_w);
            step  <= K_DBL;
            state <= PDRAW;
          end else if (do_split) begin
            coin  <= COIN_W'(coin_w - abet_w);
            step  <= K_SPA;
            state <= PDRAW;
          end else if (hit) begin
            step  <= K_HIT;
            state <= PDRAW;
          end
        PDRAW: if (!cr) cr <= 1'b1;
          else if (card_valid) begin
            cr <= 1'b0;
            if (step == K_SPA) step <= K_SPB;
            else if (step == K_SPB) begin
              nhands <= nhands + (HW+1)'(1);
              state  <= PLAY;
            end else if (step == K_DBL || nh_best >= 6'd21) begin
              if (last_hand) state <= DEALER;
              else begin
                active <= active + HW'(1);
                state  <= PLAY;
              end
            end else state <= PLAY;
          end
        DEALER: if (!all_bust && d_best < 6'(DEALER_STAND)) state <= DDRAW;
          else begin
            sidx  <= '0;
            state <= SETTLE;
          end
        DDRAW: if (!cr) cr <= 1'b1;
          else if (card_valid) begin
            cr    <= 1'b0;
            state <= DEALER;
          end
        SETTLE: begin
          coin         <= coin_sat[COIN_W-1:0];
          r_win[sidx]  <= s_win;
          r_draw[sidx] <= s_draw;
          r_lose[sidx] <= !s_win && !s_draw;
          if (settle_last) begin
            done  <= 1'b1;
            state <= DONE;
          end else sidx <= sidx + HW'(1);
        end
        DONE: if (next) begin
          done   <= 1'b0;
          r_win  <= '0;
          r_lose <= '0;
          r_draw <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_blackjack_round_ctrl.sv
// Directed bench for blackjack_round_ctrl with default parameters.
module tb_blackjack_round_ctrl;
  logic       clk = 1'b0, reset = 1'b0;
  logic       next = 1'b0, hit = 1'b0, stand = 1'b0, double = 1'b0, split = 1'b0;
  logic [3:0] bet = 4'd0;
  logic       card_valid = 1'b0;
  logic [3:0] card_value = 4'd0;
  logic [0:0] hand_sel = 1'b0;
  logic       card_req, can_split, can_double, result_valid, Win, Lose, Draw;
  logic [5:0] player_score, player_new_card, dealer_score;
  logic [0:0] active_hand;
  logic [1:0] num_hands;
  logic [4:0] current_coin;
  int checks = 0;
  int errors = 0;

  blackjack_round_ctrl dut (
    .clk(clk), .reset(reset), .next(next), .hit(hit), .stand(stand), .double(double),
    .split(split), .bet(bet), .card_req(card_req), .card_valid(card_valid),
    .card_value(card_value), .hand_sel(hand_sel), .player_score(player_score),
    .player_new_card(player_new_card), .dealer_score(dealer_score),
    .active_hand(active_hand), .num_hands(num_hands), .current_coin(current_coin),
    .can_split(can_split), .can_double(can_double), .result_valid(result_valid),
    .Win(Win), .Lose(Lose), .Draw(Draw)
  );

  always #5 clk = ~clk;

  task automatic pulse(input logic h, input logic s, input logic d, input logic sp, input logic n);
    @(negedge clk);
    hit = h; stand = s; double = d; split = sp; next = n;
    @(negedge clk);
    hit = 1'b0; stand = 1'b0; double = 1'b0; split = 1'b0; next = 1'b0;
  endtask

  task automatic start_round(input logic [3:0] b);
    bet = b;
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic give_card(input logic [3:0] v);
    int n = 0;
    while (card_req !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (card_req !== 1'b1) begin
      checks++; errors++;
      $display("FAIL card_req_timeout got=%b exp=1 (card %0d)", card_req, v);
    end else begin
      card_valid = 1'b1; card_value = v;
      @(posedge clk); #1;
      card_valid = 1'b0; card_value = 4'd0;
    end
  endtask

  task automatic wait_result(input string name);
    int n = 0;
    while (result_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (result_valid !== 1'b1) begin errors++; $display("FAIL %s result_valid got=%b exp=1", name, result_valid); end
  endtask

  task automatic deal4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    give_card(a); give_card(b); give_card(c); give_card(d);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int n = 0;
    @(negedge clk); reset = 1'b0; #1;
    checks++; if (current_coin !== 5'd10) begin errors++; $display("FAIL rst_coin got=%0d exp=10", current_coin); end
    checks++; if ({card_req, result_valid, Win, Lose, Draw} !== 5'b0) begin errors++; $display("FAIL rst_flags got=%b exp=00000", {card_req, result_valid, Win, Lose, Draw}); end
    checks++; if ({num_hands, active_hand, can_split, can_double} !== 5'b0) begin errors++; $display("FAIL rst_hands got=%b exp=00000", {num_hands, active_hand, can_split, can_double}); end
    checks++; if (player_score !== 6'd0 || dealer_score !== 6'd0) begin errors++; $display("FAIL rst_scores got=%0d/%0d exp=0/0", player_score, dealer_score); end
    @(negedge clk); reset = 1'b1;
    start_round(4'd3);
    deal4(4'd10, 4'd7, 4'd9, 4'd7);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    while (card_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (card_req !== 1'b1) begin errors++; $display("FAIL pdraw_req got=%b exp=1", card_req); end
    reset = 1'b0; #1;
    checks++; if (card_req !== 1'b0) begin errors++; $display("FAIL midreset_req got=%b exp=0", card_req); end
    checks++; if (current_coin !== 5'd10) begin errors++; $display("FAIL midreset_coin got=%0d exp=10", current_coin); end
    checks++; if ({num_hands, result_valid, Win, Lose, Draw} !== 6'b0) begin errors++; $display("FAIL midreset_flags got=%b exp=000000", {num_hands, result_valid, Win, Lose, Draw}); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_win();
    start_round(4'd3);
    checks++; if (current_coin !== 5'd7) begin errors++; $display("FAIL start_coin got=%0d exp=7", current_coin); end
    @(negedge clk);
    checks++; if (card_req !== 1'b1) begin errors++; $display("FAIL start_req got=%b exp=1", card_req); end
    deal4(4'd10, 4'd7, 4'd9, 4'd10);
    checks++; if (player_score !== 6'd19 || dealer_score !== 6'd17) begin errors++; $display("FAIL win_scores got=%0d/%0d exp=19/17", player_score, dealer_score); end
    checks++; if ({can_double, can_split} !== 2'b10) begin errors++; $display("FAIL win_legal got=%b exp=10", {can_double, can_split}); end
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_result("win");
    checks++; if ({Win, Lose, Draw} !== 3'b100) begin errors++; $display("FAIL win_flags got=%b exp=100", {Win, Lose, Draw}); end
    checks++; if (current_coin !== 5'd13) begin errors++; $display("FAIL win_coin got=%0d exp=13", current_coin); end
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL ack_valid got=%b exp=0", result_valid); end
  endtask

  task automatic test_split();
    do_reset();
    start_round(4'd2);
    deal4(4'd8, 4'd10, 4'd8, 4'd6);
    checks++; if (can_split !== 1'b1) begin errors++; $display("FAIL split_legal got=%b exp=1", can_split); end
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    give_card(4'd3); give_card(4'd10);
    @(negedge clk);
    checks++; if (num_hands !== 2'd2) begin errors++; $display("FAIL split_hands got=%0d exp=2", num_hands); end
    hand_sel = 1'b0; #1;
    checks++; if (player_score !== 6'd11) begin errors++; $display("FAIL split_h0 got=%0d exp=11", player_score); end
    hand_sel = 1'b1; #1;
    checks++; if (player_score !== 6'd18 || player_new_card !== 6'd10) begin errors++; $display("FAIL split_h1 got=%0d/%0d exp=18/10", player_score, player_new_card); end
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (active_hand !== 1'b1) begin errors++; $display("FAIL split_active got=%0d exp=1", active_hand); end
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    give_card(4'd5);
    give_card(4'd2);
    wait_result("split");
    checks++; if (dealer_score !== 6'd18) begin errors++; $display("FAIL split_dealer got=%0d exp=18", dealer_score); end
    hand_sel = 1'b0; #1;
    checks++; if ({Win, Lose, Draw} !== 3'b010) begin errors++; $display("FAIL split_res0 got=%b exp=010", {Win, Lose, Draw}); end
    hand_sel = 1'b1; #1;
    checks++; if ({Win, Lose, Draw} !== 3'b010) begin errors++; $display("FAIL split_res1 got=%b exp=010", {Win, Lose, Draw}); end
    checks++; if (current_coin !== 5'd6) begin errors++; $display("FAIL split_coin got=%0d exp=6", current_coin); end
    hand_sel = 1'b0;
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_double();
    do_reset();
    start_round(4'd5);
    deal4(4'd5, 4'd9, 4'd6, 4'd10);
    checks++; if (can_double !== 1'b1) begin errors++; $display("FAIL dbl_legal got=%b exp=1", can_double); end
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (current_coin !== 5'd0) begin errors++; $display("FAIL dbl_debit got=%0d exp=0", current_coin); end
    give_card(4'd10);
    wait_result("double");
    checks++; if (player_score !== 6'd21 || Win !== 1'b1) begin errors++; $display("FAIL dbl_win got=%0d/%b exp=21/1", player_score, Win); end
    checks++; if (current_coin !== 5'd20) begin errors++; $display("FAIL dbl_coin got=%0d exp=20", current_coin); end
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_saturate();
    start_round(4'd10);
    deal4(4'd10, 4'd7, 4'd9, 4'd10);
    pulse(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_result("hit_stand");
    checks++; if (current_coin !== 5'd30 || player_score !== 6'd19) begin errors++; $display("FAIL hit_stand got=%0d/%0d exp=30/19", current_coin, player_score); end
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    start_round(4'd15);
    deal4(4'd10, 4'd7, 4'd9, 4'd10);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_result("saturate");
    checks++; if (current_coin !== 5'd31) begin errors++; $display("FAIL sat_coin got=%0d exp=31", current_coin); end
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    start_round(4'd0);
    repeat (3) @(negedge clk);
    checks++; if (card_req !== 1'b0 || current_coin !== 5'd31) begin errors++; $display("FAIL bet0 got=%b/%0d exp=0/31", card_req, current_coin); end
  endtask

  task automatic test_push();
    do_reset();
    start_round(4'd11);
    repeat (3) @(negedge clk);
    checks++; if (card_req !== 1'b0 || current_coin !== 5'd10) begin errors++; $display("FAIL overbet got=%b/%0d exp=0/10", card_req, current_coin); end
    start_round(4'd2);
    deal4(4'd10, 4'd10, 4'd8, 4'd8);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_result("push");
    checks++; if ({Win, Lose, Draw} !== 3'b001 || current_coin !== 5'd10) begin errors++; $display("FAIL push got=%b/%0d exp=001/10", {Win, Lose, Draw}, current_coin); end
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_all_bust();
    start_round(4'd1);
    deal4(4'd10, 4'd6, 4'd6, 4'd5);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    give_card(4'd10);
    wait_result("all_bust");
    checks++; if (Lose !== 1'b1 || dealer_score !== 6'd11) begin errors++; $display("FAIL bust got=%b/%0d exp=1/11", Lose, dealer_score); end
    checks++; if (current_coin !== 5'd9) begin errors++; $display("FAIL bust_coin got=%0d exp=9", current_coin); end
    hand_sel = 1'b1; #1;
    checks++; if ({Win, Lose, Draw} !== 3'b000) begin errors++; $display("FAIL sel_range got=%b exp=000", {Win, Lose, Draw}); end
    hand_sel = 1'b0;
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_natural();
    logic [4:0] exp_coin;
`ifdef BLACKJACK_BONUS_EN
    exp_coin = 5'd16;
`else
    exp_coin = 5'd14;
`endif
    do_reset();
    start_round(4'd4);
    deal4(4'd1, 4'd9, 4'd10, 4'd8);
    checks++; if (player_score !== 6'd21) begin errors++; $display("FAIL nat_score got=%0d exp=21", player_score); end
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_result("natural");
    checks++; if (Win !== 1'b1 || current_coin !== exp_coin) begin errors++; $display("FAIL nat_coin got=%b/%0d exp=1/%0d", Win, current_coin, exp_coin); end
    pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_win();
    test_split();
    test_double();
    test_saturate();
    test_push();
    test_all_bust();
    test_natural();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
